// File: rtl/ssd_display_sched.sv
// ssd_display_sched: 4-digit SSD scan sequencer and source arbiter (SCORE/HIGH/STOP); define LEADING_ZERO_BLANK_EN to blank leading zeros of the live score
`ifndef STOP
`define STOP 2'd3
`endif
module ssd_display_sched #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [3:0]  BLANK_CYC    = 4'd8,
  parameter logic [7:0]  HOLD_FRAMES  = 8'd200,
  parameter logic [7:0]  FLASH_FRAMES = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_highscore,
  input  logic [1:0] state,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] p1,
  input  logic [3:0] p0,
  output logic [3:0] ssd_ctl,
  output logic [3:0] ssd_in,
  output logic [1:0] src,
  output logic       frame_tick
);
  typedef enum logic [1:0] {SRC_SCORE = 2'd0, SRC_HIGH = 2'd1, SRC_STOP = 2'd2} src_t;
  src_t        r_src, w_src_n;
  logic [15:0] r_presc;
  logic [1:0]  r_idx;
  logic [7:0]  r_hold, w_hold_n, r_fcnt, w_fcnt_n;
  logic        r_fon, w_fon_n, r_pb, r_tick;
  logic [3:0]  r_ctl, r_in, w_val, w_sel;
  logic        w_term, w_rise, w_stop, w_lz, w_blank;
  assign w_term     = r_presc == SCAN_DIV - 16'd1;
  assign w_rise     = pb_highscore & ~r_pb;
  assign w_stop     = state == `STOP;
  assign w_sel      = ~(4'b1000 >> r_idx);
  assign ssd_ctl    = r_ctl;
  assign ssd_in     = r_in;
  assign src        = r_src;
  assign frame_tick = r_tick;
  // slot prescaler, digit index, end-of-frame pulse and button edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
      r_pb    <= 1'b0;
    end else begin
      r_presc <= w_term ? '0 : r_presc + 16'd1;
      r_idx   <= w_term ? r_idx + 2'd1 : r_idx;
      r_tick  <= w_term && r_idx == 2'd3;
      r_pb    <= pb_highscore;
    end
  end
  // digit value and blanking for the current slot under the current source
  always_comb begin
    w_val = r_idx == 2'd0 ? in0 :
            r_idx == 2'd1 ? in1 :
            r_idx == 2'd2 ? (r_src == SRC_HIGH ? p1 : in2) :
                            (r_src == SRC_HIGH ? p0 : in3);
`ifdef LEADING_ZERO_BLANK_EN
    w_lz = r_src == SRC_SCORE &&
           ((r_idx == 2'd0 && in0 == 4'd0) ||
            (r_idx == 2'd1 && in0 == 4'd0 && in1 == 4'd0) ||
            (r_idx == 2'd2 && in0 == 4'd0 && in1 == 4'd0 && in2 == 4'd0));
`else
    w_lz = 1'b0;
`endif
    w_blank = r_presc < {12'd0, BLANK_CYC} || w_lz || (r_src == SRC_STOP && (r_idx[1] || !r_fon));
  end
  // registered drive into the segment decoder, one cycle behind the scan index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl <= 4'b1111;
      r_in  <= 4'd0;
    end else begin
      r_ctl <= w_blank ? 4'b1111 : w_sel;
      r_in  <= w_blank ? 4'd0 : w_val;
    end
  end
  // source state, high-score hold counter and flash phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src  <= SRC_SCORE;
      r_hold <= '0;
      r_fcnt <= '0;
      r_fon  <= 1'b1;
    end else begin
      r_src  <= w_src_n;
      r_hold <= w_hold_n;
      r_fcnt <= w_fcnt_n;
      r_fon  <= w_fon_n;
    end
  end
  // source arbitration: button press beats hold expiry beats STOP entry/exit; flash runs only while in STOP
  always_comb begin
    w_src_n  = r_src;
    w_hold_n = r_hold;
    w_fcnt_n = r_fcnt;
    w_fon_n  = r_fon;
    if (w_rise) begin
      w_src_n  = SRC_HIGH;
      w_hold_n = HOLD_FRAMES;
    end else if (r_src == SRC_HIGH && r_tick) begin
      if (r_hold == 8'd1) w_src_n = w_stop ? SRC_STOP : SRC_SCORE;
      else w_hold_n = r_hold - 8'd1;
    end else if (r_src == SRC_SCORE && w_stop) begin
      w_src_n  = SRC_STOP;
      w_fcnt_n = '0;
      w_fon_n  = 1'b1;
    end else if (r_src == SRC_STOP && !w_stop) begin
      w_src_n = SRC_SCORE;
    end
    if (w_src_n != SRC_STOP) begin
      w_fcnt_n = '0;
      w_fon_n  = 1'b1;
    end else if (r_src == SRC_STOP && r_tick) begin
      w_fcnt_n = r_fcnt == FLASH_FRAMES - 8'd1 ? 8'd0 : r_fcnt + 8'd1;
      w_fon_n  = r_fcnt == FLASH_FRAMES - 8'd1 ? !r_fon : r_fon;
    end
  end
endmodule

// File: tb/tb_ssd_display_sched.sv
// tb_ssd_display_sched: directed self-checking bench for ssd_display_sched
`ifndef STOP
`define STOP 2'd3
`endif
module tb_ssd_display_sched;
  localparam logic [15:0] SEL  = 16'h7BDE;
  localparam logic [15:0] SVIS = 16'h7BFF;
  localparam logic [15:0] ALLB = 16'hFFFF;
  logic       clk = 1'b0, rst = 1'b1, pb = 1'b0;
  logic [1:0] state = 2'd0;
  logic [3:0] in0 = 4'd1, in1 = 4'd2, in2 = 4'd3, in3 = 4'd4, p1 = 4'd9, p0 = 4'd7;
  logic [3:0] ssd_ctl, ssd_in;
  logic [1:0] src;
  logic       frame_tick;
  int         checks = 0, errors = 0, n;
  ssd_display_sched #(
    .SCAN_DIV(16'd4), .BLANK_CYC(4'd1), .HOLD_FRAMES(8'd3), .FLASH_FRAMES(8'd2)
  ) dut (
    .clk(clk), .rst(rst), .pb_highscore(pb), .state(state),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .p1(p1), .p0(p0),
    .ssd_ctl(ssd_ctl), .ssd_in(ssd_in), .src(src), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_frame(input string tag, input logic [1:0] s, input logic [15:0] ctl, input logic [15:0] val);
    for (int j = 1; j <= 16; j++) begin
      int   slot;
      logic bl;
      @(negedge clk);
      slot = (j - 1) / 4;
      bl   = ((j - 1) % 4) == 0;
      chk($sformatf("%s_j%0d_ctl", tag, j), {28'd0, ssd_ctl}, {28'd0, bl ? 4'hF : ctl[15-4*slot -: 4]});
      chk($sformatf("%s_j%0d_in", tag, j), {28'd0, ssd_in}, {28'd0, bl ? 4'h0 : val[15-4*slot -: 4]});
      chk($sformatf("%s_j%0d_src", tag, j), {30'd0, src}, {30'd0, s});
      chk($sformatf("%s_j%0d_tick", tag, j), {31'd0, frame_tick}, {31'd0, j == 16});
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctl", {28'd0, ssd_ctl}, 32'hF);
    chk("rst_in", {28'd0, ssd_in}, 32'h0);
    chk("rst_src", {30'd0, src}, 32'd0);
    chk("rst_tick", {31'd0, frame_tick}, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_ctl", {28'd0, ssd_ctl}, 32'hB);
    chk("pre_rst_in", {28'd0, ssd_in}, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ctl", {28'd0, ssd_ctl}, 32'hF);
    chk("async_rst_in", {28'd0, ssd_in}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 40);
    chk("first_tick_cycles", n, 16);
    chk("first_tick_src", {30'd0, src}, 32'd0);
    chk_frame("score_a", 2'd0, SEL, 16'h1234);
    chk_frame("score_b", 2'd0, SEL, 16'h1234);
    pb = 1'b1;
    chk_frame("high_1", 2'd1, SEL, 16'h1297);
    chk_frame("high_2", 2'd1, SEL, 16'h1297);
    chk_frame("high_3", 2'd1, SEL, 16'h1297);
    chk_frame("high_exit", 2'd0, SEL, 16'h1234);
    pb = 1'b0;
    state = `STOP;
    chk_frame("stop_1", 2'd2, SVIS, 16'h1200);
    chk_frame("stop_2", 2'd2, SVIS, 16'h1200);
    chk_frame("stop_3", 2'd2, ALLB, 16'h0000);
    chk_frame("stop_4", 2'd2, ALLB, 16'h0000);
    state = 2'd0;
    chk_frame("stop_exit", 2'd0, SEL, 16'h1234);
    state = `STOP;
    chk_frame("sp_stop", 2'd2, SVIS, 16'h1200);
    pb = 1'b1;
    chk_frame("sp_high_1", 2'd1, SEL, 16'h1297);
    pb = 1'b0;
    chk_frame("sp_high_2", 2'd1, SEL, 16'h1297);
    pb = 1'b1;
    chk_frame("sp_high_3", 2'd1, SEL, 16'h1297);
    chk_frame("sp_high_4", 2'd1, SEL, 16'h1297);
    chk_frame("sp_high_5", 2'd1, SEL, 16'h1297);
    chk_frame("sp_stop_1", 2'd2, SVIS, 16'h1200);
    chk_frame("sp_stop_2", 2'd2, SVIS, 16'h1200);
    chk_frame("sp_stop_3", 2'd2, ALLB, 16'h0000);
    state = 2'd0;
    pb = 1'b0;
    in0 = 4'd0; in1 = 4'd0; in2 = 4'd5; in3 = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    chk_frame("lz_score", 2'd0, 16'hFFDE, 16'h0050);
`else
    chk_frame("lz_score", 2'd0, SEL, 16'h0050);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
